pcpi_result_tx: RTL and testbench

Result-return stage that sits directly downstream of the PCPI coprocessor. It captures each 32-bit result written back on the PCPI interface into a small FIFO. It then returns each result to the host over the pin-limited interface as 8 nibbles, using a 4-phase valid/ack handshake that mirrors the nibble-wise instruction load path. This closes the loop so the host can read back `pcpi_rd` through `uo_out`.

---
 rtl/pcpi_result_tx.sv | 141 ++++++++++++++
 tb/tb_pcpi_result_tx.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcpi_result_tx.sv
// rtl/pcpi_result_tx.sv - buffers PCPI results and returns them nibble-wise over a 4-phase valid/ack handshake
module pcpi_result_tx #(
  parameter int NIBBLES = 8,
  parameter int DEPTH   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pcpi_ready,
  input  logic                       pcpi_wr,
  input  logic [4*NIBBLES-1:0]       pcpi_rd,
  input  logic                       tx_ack,
  output logic [3:0]                 tx_nibble,
  output logic                       tx_valid,
  output logic                       tx_last,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     pending,
  output logic                       overflow
);

  localparam int W  = 4 * NIBBLES;
  localparam int AW = $clog2(DEPTH);
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    ACKLOW  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty;
  logic [W-1:0]  head;

  logic [W-1:0]  shift;
  logic [IW-1:0] index;

  logic          load_head, shift_next, pop, valid_next;
  logic          wr_req, wr_en, drop;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr[AW-1:0]];

  // A pop frees a slot on the same edge, so a write to a full FIFO is still accepted then.
  assign wr_req = pcpi_ready && pcpi_wr;
  assign wr_en  = wr_req && (!full || pop);
  assign drop   = wr_req && full && !pop;

  assign pending = count;
  assign busy    = full;
  assign tx_last = tx_valid && (index == LAST_IDX);

  // Result storage; contents need no reset because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= pcpi_rd;
    end
  end

  // FIFO pointers and the sticky drop flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (drop)  overflow <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode for the per-nibble valid/ack handshake.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!empty) state_next = PRESENT;
      PRESENT: if (tx_ack) state_next = ACKLOW;
      ACKLOW:  if (!tx_ack) state_next = (index == LAST_IDX) ? IDLE : PRESENT;
      default: state_next = IDLE;
    endcase
  end

  // Datapath strobes derived from the current state and handshake inputs.
  always_comb begin
    load_head  = 1'b0;
    shift_next = 1'b0;
    pop        = 1'b0;
    valid_next = (state_next == PRESENT);
    case (state)
      IDLE:    load_head = !empty;
      ACKLOW:  begin
        if (!tx_ack) begin
          if (index == LAST_IDX) pop = 1'b1;
          else                   shift_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Shift register, nibble index and the registered host-facing outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift     <= '0;
      index     <= '0;
      tx_valid  <= 1'b0;
      tx_nibble <= 4'h0;
    end else begin
      tx_valid <= valid_next;
      if (load_head) begin
        shift     <= head;
        index     <= '0;
        tx_nibble <= head[3:0];
      end else if (shift_next) begin
        shift     <= shift >> 4;
        index     <= index + 1'b1;
        tx_nibble <= shift[7:4];
      end else if (pop) begin
        index <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pcpi_result_tx.sv
// tb/tb_pcpi_result_tx.sv - directed self-checking bench for pcpi_result_tx
module tb_pcpi_result_tx;

  localparam int NIBBLES = 8;
  localparam int DEPTH   = 2;

  logic        clk;
  logic        rst_n;
  logic        pcpi_ready;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        tx_ack;
  logic [3:0]  tx_nibble;
  logic        tx_valid;
  logic        tx_last;
  logic        busy;
  logic [1:0]  pending;
  logic        overflow;

  int checks;
  int failures;

  pcpi_result_tx #(.NIBBLES(NIBBLES), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pcpi_ready (pcpi_ready),
    .pcpi_wr    (pcpi_wr),
    .pcpi_rd    (pcpi_rd),
    .tx_ack     (tx_ack),
    .tx_nibble  (tx_nibble),
    .tx_valid   (tx_valid),
    .tx_last    (tx_last),
    .busy       (busy),
    .pending    (pending),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled at the falling edge.
  task automatic pulse(input logic wr, input logic [31:0] data);
    pcpi_ready = 1'b1;
    pcpi_wr    = wr;
    pcpi_rd    = data;
    @(negedge clk);
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
  endtask

  task automatic apply_reset();
    tx_ack     = 1'b0;
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
    rst_n      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits for a presented nibble, then performs ack-high / ack-low.
  task automatic recv_nibble(output logic [3:0] nib, output logic last, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (tx_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    nib  = tx_nibble;
    last = tx_last;
    if (ok) begin
      tx_ack = 1'b1;
      @(negedge clk);
      tx_ack = 1'b0;
    end
  endtask

  task automatic recv_word(input logic [31:0] exp, input string name);
    logic [3:0] nib;
    logic       last;
    bit         ok;
    logic [31:0] e;
    e = exp;
    for (int k = 0; k < NIBBLES; k++) begin
      recv_nibble(nib, last, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL %s nibble%0d timeout: tx_valid=%b required 1", name, k, tx_valid);
        return;
      end
      checks++;
      if (nib !== e[4*k +: 4]) begin
        failures++;
        $display("FAIL %s nibble%0d: got %h required %h", name, k, nib, e[4*k +: 4]);
      end
      checks++;
      if (last !== (k == NIBBLES - 1)) begin
        failures++;
        $display("FAIL %s tx_last%0d: got %b required %b", name, k, last, (k == NIBBLES - 1));
      end
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    tx_ack     = 1'b1;
    pcpi_ready = 1'b1;
    pcpi_wr    = 1'b1;
    pcpi_rd    = 32'hDEADBEEF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({tx_valid, tx_nibble, tx_last, busy, pending, overflow} !== 10'd0) begin
        failures++;
        $display("FAIL reset cycle%0d: valid=%b nib=%h last=%b busy=%b pending=%0d ovf=%b required all 0",
                 c, tx_valid, tx_nibble, tx_last, busy, pending, overflow);
      end
    end
    tx_ack     = 1'b0;
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
    rst_n      = 1'b1;
    @(negedge clk);
    checks++;
    if (pending !== 2'd0 || tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: pending=%0d valid=%b required 0 0", pending, tx_valid);
    end
  endtask

  task automatic test_single();
    pulse(1'b1, 32'h1234ABCD);
    checks++;
    if (pending !== 2'd1 || tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_capture: pending=%0d valid=%b required 1 0", pending, tx_valid);
    end
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || tx_nibble !== 4'hD) begin
      failures++;
      $display("FAIL single_first_present: valid=%b nib=%h required 1 d", tx_valid, tx_nibble);
    end
    recv_word(32'h1234ABCD, "single");
    checks++;
    if (pending !== 2'd1) begin
      failures++;
      $display("FAIL single_pending_before_pop: got %0d required 1", pending);
    end
    @(negedge clk);
    checks++;
    if (pending !== 2'd0 || tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_done: pending=%0d valid=%b required 0 0", pending, tx_valid);
    end
  endtask

  task automatic test_no_write();
    pulse(1'b0, 32'hFFFFFFFF);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (pending !== 2'd0 || tx_valid !== 1'b0) begin
        failures++;
        $display("FAIL no_write cycle%0d: pending=%0d valid=%b required 0 0", c, pending, tx_valid);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_overflow();
    int vcount;
    tx_ack = 1'b0;
    pulse(1'b1, 32'h11111111);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL ovf_busy_after_1st: got %b required 0", busy);
    end
    pulse(1'b1, 32'h22222222);
    checks++;
    if (busy !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_busy_after_2nd: busy=%b ovf=%b required 1 0", busy, overflow);
    end
    pulse(1'b1, 32'h33333333);
    checks++;
    if (overflow !== 1'b1 || pending !== 2'd2) begin
      failures++;
      $display("FAIL ovf_after_3rd: ovf=%b pending=%0d required 1 2", overflow, pending);
    end
    recv_word(32'h11111111, "ovf_first");
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || pending !== 2'd1) begin
      failures++;
      $display("FAIL ovf_after_pop: busy=%b pending=%0d required 0 1", busy, pending);
    end
    recv_word(32'h22222222, "ovf_second");
    vcount = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (tx_valid === 1'b1) vcount++;
    end
    checks++;
    if (vcount != 0 || pending !== 2'd0 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_drained: extra_valid=%0d pending=%0d ovf=%b required 0 0 1", vcount, pending, overflow);
    end
  endtask

  task automatic test_full_pop();
    logic [3:0]  nib;
    logic        last;
    bit          ok;
    logic [31:0] h;
    apply_reset();
    h = 32'hA0A0A0A1;
    pulse(1'b1, h);
    pulse(1'b1, 32'hB0B0B0B2);
    checks++;
    if (busy !== 1'b1 || pending !== 2'd2 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL fullpop_setup: busy=%b pending=%0d ovf=%b required 1 2 0", busy, pending, overflow);
    end
    for (int k = 0; k < NIBBLES - 1; k++) begin
      recv_nibble(nib, last, ok);
      checks++;
      if (!ok || nib !== h[4*k +: 4]) begin
        failures++;
        $display("FAIL fullpop_head nibble%0d: got %h ok=%b required %h", k, nib, ok, h[4*k +: 4]);
      end
    end
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (tx_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok || tx_last !== 1'b1 || tx_nibble !== 4'hA) begin
      failures++;
      $display("FAIL fullpop_last_nibble: ok=%b last=%b nib=%h required 1 1 a", ok, tx_last, tx_nibble);
    end
    tx_ack = 1'b1;
    @(negedge clk);
    tx_ack = 1'b0;
    pulse(1'b1, 32'h5A5A5A5A);
    checks++;
    if (overflow !== 1'b0 || pending !== 2'd2 || busy !== 1'b1) begin
      failures++;
      $display("FAIL fullpop_same_edge: ovf=%b pending=%0d busy=%b required 0 2 1", overflow, pending, busy);
    end
    recv_word(32'hB0B0B0B2, "fullpop_second");
    recv_word(32'h5A5A5A5A, "fullpop_third");
    @(negedge clk);
    checks++;
    if (pending !== 2'd0 || busy !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL fullpop_drained: pending=%0d busy=%b ovf=%b required 0 0 0", pending, busy, overflow);
    end
  endtask

  task automatic test_stuck_ack_reset();
    int          vcount;
    logic [3:0]  seen;
    logic [3:0]  nib;
    logic        last;
    bit          ok;
    logic [31:0] w;
    apply_reset();
    w = 32'hCAFEF00D;
    tx_ack = 1'b1;
    pulse(1'b1, w);
    vcount = 0;
    seen   = 4'h0;
    for (int c = 0; c < 8; c++) begin
      if (tx_valid === 1'b1) begin
        vcount++;
        seen = tx_nibble;
      end
      @(negedge clk);
    end
    checks++;
    if (vcount != 1 || seen !== 4'hD) begin
      failures++;
      $display("FAIL stuck_ack_pulse: valid_cycles=%0d nib=%h required 1 d", vcount, seen);
    end
    tx_ack = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 3; k++) begin
      recv_nibble(nib, last, ok);
      checks++;
      if (!ok || nib !== w[4*k +: 4]) begin
        failures++;
        $display("FAIL stuck_nibble%0d: got %h ok=%b required %h", k, nib, ok, w[4*k +: 4]);
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (tx_valid !== 1'b0 || pending !== 2'd0 || tx_nibble !== 4'h0) begin
      failures++;
      $display("FAIL midreset: valid=%b pending=%0d nib=%h required 0 0 0", tx_valid, pending, tx_nibble);
    end
    vcount = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (tx_valid === 1'b1) vcount++;
    end
    checks++;
    if (vcount != 0) begin
      failures++;
      $display("FAIL midreset_quiet: valid_cycles=%0d required 0", vcount);
    end
    pulse(1'b1, 32'h00000007);
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || tx_nibble !== 4'h7) begin
      failures++;
      $display("FAIL after_reset_first: valid=%b nib=%h required 1 7", tx_valid, tx_nibble);
    end
    recv_word(32'h00000007, "after_reset");
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    tx_ack     = 1'b0;
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
    pcpi_rd    = 32'h0;
    test_reset();
    test_single();
    test_no_write();
    test_overflow();
    test_full_pop();
    test_stuck_ack_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
